// File: rtl/rc_spike_accum_pkg.sv
// Shared types for the reservoir readout accumulator: FSM state encoding.
package rc_spike_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/rc_weight_ram.sv
// Readout weight store: one write port, one read port, registered read, no array reset.
module rc_weight_ram #(
  parameter int DEPTH = 64,
  parameter int DW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rc_spike_accum.sv
// Reservoir readout accumulator: per-lane signed sum of the weights of fired neurons.
// Optional bias word and output saturation when RC_ACCUM_BIAS_EN is defined.
//
// state | meaning
// IDLE  | accept weight writes or a spike vector
// RUN   | one weight-RAM read per cycle, accumulate the previous read
// DRAIN | add the last word, load the output register
// OUT   | hold the result until the consumer takes it
module rc_spike_accum #(
  parameter  int NH = 64,
  parameter  int NO = 4,
  parameter  int WS = 8,
  localparam int W  = $clog2(NH) + WS,
  localparam int AW = $clog2(NH + 1)
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iValid_AS_Spike,
  output logic            oReady_AS_Spike,
  input  logic [NH-1:0]   iData_AS_Spike,
  input  logic            iValid_AS_Weight,
  output logic            oReady_AS_Weight,
  input  logic [AW-1:0]   iAddr_AS_Weight,
  input  logic [NO*WS-1:0] iData_AS_Weight,
  output logic            oValid_BM_RcAccum,
  input  logic            iReady_BM_RcAccum,
  output logic [NO*W-1:0] oData_BM_RcAccum
);
  import rc_spike_accum_pkg::*;

  localparam int IW = $clog2(NH);
`ifdef RC_ACCUM_BIAS_EN
  localparam int DEPTH = NH + 1;
  localparam int ACC_W = W + 1;
  localparam bit BIAS  = 1'b1;
`else
  localparam int DEPTH = NH;
  localparam int ACC_W = W;
  localparam bit BIAS  = 1'b0;
`endif
  localparam int RAW = $clog2(DEPTH);

  state_t           state, state_nxt;
  logic             rdy_q;
  logic [NH-1:0]    spike_q;
  logic [IW-1:0]    idx;
  logic             bias_ph;
  logic             add_en, add_bit, add_init;
  logic             spike_acc, wt_acc, rd_en;
  logic [RAW-1:0]   rd_addr;
  logic [NO*WS-1:0] rd_data;
  logic [NO*W-1:0]  res;

  assign spike_acc        = rdy_q & iValid_AS_Spike;
  assign oReady_AS_Spike  = rdy_q;
  // A simultaneous spike wins, so weight ready drops in that cycle.
  assign oReady_AS_Weight = rdy_q & ~iValid_AS_Spike;
  assign wt_acc           = oReady_AS_Weight & iValid_AS_Weight;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = RAW'(idx);
    case (state)
      IDLE:  if (spike_acc) state_nxt = RUN;
      RUN: begin
        rd_en = 1'b1;
        if (bias_ph)                 rd_addr   = RAW'(NH);
        else if (idx == IW'(NH - 1)) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = OUT;
      OUT:   if (iReady_BM_RcAccum) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      spike_q <= '0;
      idx     <= '0;
      bias_ph <= 1'b0;
    end else if (spike_acc) begin
      spike_q <= iData_AS_Spike;
      idx     <= '0;
      bias_ph <= BIAS;
    end else if (state == RUN) begin
      if (bias_ph) bias_ph <= 1'b0;
      else         idx     <= idx + 1'b1;
    end
  end

  // Per-read tags that line up with the RAM data one cycle later.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      add_en   <= 1'b0;
      add_bit  <= 1'b0;
      add_init <= 1'b0;
    end else begin
      add_en   <= rd_en;
      add_bit  <= bias_ph | spike_q[idx];
      add_init <= bias_ph;
    end
  end

  rc_weight_ram #(.DEPTH(DEPTH), .DW(NO*WS), .AW(RAW)) u_ram (
    .clk   (iCLK),
    .we    (wt_acc && (iAddr_AS_Weight < AW'(DEPTH))),
    .waddr (iAddr_AS_Weight[RAW-1:0]),
    .wdata (iData_AS_Weight),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  for (genvar o = 0; o < NO; o++) begin : g_lane
    logic signed [ACC_W-1:0] acc, acc_sum, w_ext;

    assign w_ext   = ACC_W'(signed'(rd_data[o*WS +: WS]));
    assign acc_sum = add_init ? w_ext : (add_bit ? acc + w_ext : acc);

    always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST)          acc <= '0;
      else if (spike_acc) acc <= '0;
      else if (add_en)    acc <= acc_sum;
    end

`ifdef RC_ACCUM_BIAS_EN
    // Top two bits disagree only when the sum left the W-bit range.
    assign res[o*W +: W] = (acc_sum[ACC_W-1] != acc_sum[ACC_W-2]) ?
                           (acc_sum[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) :
                           acc_sum[W-1:0];
`else
    assign res[o*W +: W] = acc_sum;
`endif
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rdy_q             <= 1'b0;
      oValid_BM_RcAccum <= 1'b0;
      oData_BM_RcAccum  <= '0;
    end else begin
      rdy_q <= (state_nxt == IDLE);
      if (state == DRAIN) begin
        oValid_BM_RcAccum <= 1'b1;
        oData_BM_RcAccum  <= res;
      end else if (state == OUT && iReady_BM_RcAccum) begin
        oValid_BM_RcAccum <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rc_spike_accum.sv
// Bench for rc_spike_accum (NH=8, NO=2, WS=4): random weights/spikes against a sum-of-weights model.
// Bias scenarios are built in when RC_ACCUM_BIAS_EN is defined.
module tb_rc_spike_accum;
  localparam int NH = 8;
  localparam int NO = 2;
  localparam int WS = 4;
  localparam int W  = 7;
  localparam int AW = 4;
`ifdef RC_ACCUM_BIAS_EN
  localparam bit BIAS = 1'b1;
  localparam int LAT  = NH + 3;
`else
  localparam bit BIAS = 1'b0;
  localparam int LAT  = NH + 2;
`endif

  logic            iCLK = 1'b0;
  logic            iRST = 1'b0;
  logic            iValid_AS_Spike = 1'b0;
  logic            oReady_AS_Spike;
  logic [NH-1:0]   iData_AS_Spike = '0;
  logic            iValid_AS_Weight = 1'b0;
  logic            oReady_AS_Weight;
  logic [AW-1:0]   iAddr_AS_Weight = '0;
  logic [NO*WS-1:0] iData_AS_Weight = '0;
  logic            oValid_BM_RcAccum;
  logic            iReady_BM_RcAccum = 1'b0;
  logic [NO*W-1:0] oData_BM_RcAccum;

  int checks = 0;
  int errors = 0;
  int wm [NH+1][NO];

  always #5 iCLK = ~iCLK;

  rc_spike_accum #(.NH(NH), .NO(NO), .WS(WS)) dut (
    .iCLK              (iCLK),
    .iRST              (iRST),
    .iValid_AS_Spike   (iValid_AS_Spike),
    .oReady_AS_Spike   (oReady_AS_Spike),
    .iData_AS_Spike    (iData_AS_Spike),
    .iValid_AS_Weight  (iValid_AS_Weight),
    .oReady_AS_Weight  (oReady_AS_Weight),
    .iAddr_AS_Weight   (iAddr_AS_Weight),
    .iData_AS_Weight   (iData_AS_Weight),
    .oValid_BM_RcAccum (oValid_BM_RcAccum),
    .iReady_BM_RcAccum (iReady_BM_RcAccum),
    .oData_BM_RcAccum  (oData_BM_RcAccum)
  );

  // Reference: bias (if built in) plus weights of fired neurons, clamped to W bits.
  function automatic int expect_lane(input logic [NH-1:0] vec, input int o);
    int s;
    s = BIAS ? wm[NH][o] : 0;
    for (int n = 0; n < NH; n++)
      if (vec[n]) s += wm[n][o];
    if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
    if (s < -(1 << (W-1)))    s = -(1 << (W-1));
    return s;
  endfunction

  function automatic int dut_lane(input int o);
    logic signed [W-1:0] lv;
    lv = oData_BM_RcAccum[o*W +: W];
    return int'(lv);
  endfunction

  task automatic write_weight(input int addr, input int l0, input int l1);
    int n;
    n = 0;
    iAddr_AS_Weight  = AW'(addr);
    iData_AS_Weight  = {WS'(l1), WS'(l0)};
    iValid_AS_Weight = 1'b1;
    while (oReady_AS_Weight !== 1'b1 && n < 200) begin @(negedge iCLK); n++; end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL weight_ready_timeout: ready=%b after %0d cycles, required 1", oReady_AS_Weight, n);
    end
    @(negedge iCLK);
    iValid_AS_Weight = 1'b0;
    if (addr < NH || BIAS) begin wm[addr][0] = l0; wm[addr][1] = l1; end
  endtask

  task automatic run_vector(input logic [NH-1:0] vec, input int hold, input string name);
    int n, lat, got, exp_v;
    logic [NO*W-1:0] snap;
    n = 0;
    iData_AS_Spike  = vec;
    iValid_AS_Spike = 1'b1;
    while (oReady_AS_Spike !== 1'b1 && n < 200) begin @(negedge iCLK); n++; end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL %s spike_ready_timeout: ready=%b, required 1", name, oReady_AS_Spike);
    end
    @(negedge iCLK);
    iValid_AS_Spike = 1'b0;
    lat = 1;
    while (oValid_BM_RcAccum !== 1'b1 && lat < 200) begin @(negedge iCLK); lat++; end
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, lat, LAT);
    end
    for (int o = 0; o < NO; o++) begin
      got = dut_lane(o);
      exp_v = expect_lane(vec, o);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL %s lane%0d: vec=%h got %0d, required %0d", name, o, vec, got, exp_v);
      end
    end
    snap = oData_BM_RcAccum;
    repeat (hold) begin
      @(negedge iCLK);
      checks++;
      if (oData_BM_RcAccum !== snap || oValid_BM_RcAccum !== 1'b1 || oReady_AS_Spike !== 1'b0) begin
        errors++;
        $display("FAIL %s backpressure_hold: data=%h valid=%b rdy=%b, required data=%h valid=1 rdy=0",
                 name, oData_BM_RcAccum, oValid_BM_RcAccum, oReady_AS_Spike, snap);
      end
    end
    iReady_BM_RcAccum = 1'b1;
    @(negedge iCLK);
    iReady_BM_RcAccum = 1'b0;
    checks++;
    if (oValid_BM_RcAccum !== 1'b0 || oReady_AS_Spike !== 1'b1) begin
      errors++;
      $display("FAIL %s handshake: valid=%b rdy=%b, required valid=0 rdy=1",
               name, oValid_BM_RcAccum, oReady_AS_Spike);
    end
  endtask

  task automatic test_reset;
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);
    checks++;
    if (oValid_BM_RcAccum !== 1'b0 || oData_BM_RcAccum !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h, required 0/0", oValid_BM_RcAccum, oData_BM_RcAccum);
    end
    checks++;
    if (oReady_AS_Spike !== 1'b0 || oReady_AS_Weight !== 1'b0) begin
      errors++;
      $display("FAIL reset_readies: spike=%b weight=%b, required 0/0", oReady_AS_Spike, oReady_AS_Weight);
    end
    iRST = 1'b1;
    #1;
    checks++;
    if (oReady_AS_Spike !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_registered: got %b before first edge, required 0", oReady_AS_Spike);
    end
    @(negedge iCLK);
    checks++;
    if (oReady_AS_Spike !== 1'b1 || oReady_AS_Weight !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: spike=%b weight=%b, required 1/1", oReady_AS_Spike, oReady_AS_Weight);
    end
  endtask

  task automatic test_basic;
    for (int a = 0; a < NH; a++) write_weight(a, 1, -8);
    write_weight(NH, 0, 0);
    run_vector(8'hFF, 0, "all_fired");
    run_vector(8'h00, 0, "none_fired");
    run_vector(8'h05, 0, "pattern_05");
  endtask

  task automatic test_back_to_back;
    run_vector(8'hA3, 5, "backpressure");
    run_vector(8'h3C, 0, "after_backpressure");
  endtask

  task automatic test_collision;
    int lat, wacc;
    int exp_v [NO];
    for (int o = 0; o < NO; o++) exp_v[o] = expect_lane(8'hFF, o);
    iData_AS_Spike   = 8'hFF;
    iValid_AS_Spike  = 1'b1;
    iAddr_AS_Weight  = '0;
    iData_AS_Weight  = {WS'(-3), WS'(5)};
    iValid_AS_Weight = 1'b1;
    #1;
    checks++;
    if (oReady_AS_Weight !== 1'b0 || oReady_AS_Spike !== 1'b1) begin
      errors++;
      $display("FAIL collision_priority: wready=%b sready=%b, required 0/1", oReady_AS_Weight, oReady_AS_Spike);
    end
    @(negedge iCLK);
    iValid_AS_Spike = 1'b0;
    lat = 1;
    wacc = 0;
    while (oValid_BM_RcAccum !== 1'b1 && lat < 200) begin
      if (oReady_AS_Weight === 1'b1) wacc++;
      @(negedge iCLK);
      lat++;
    end
    checks++;
    if (wacc != 0 || lat !== LAT) begin
      errors++;
      $display("FAIL collision_busy: weight accepted %0d times, latency %0d, required 0 and %0d", wacc, lat, LAT);
    end
    for (int o = 0; o < NO; o++) begin
      checks++;
      if (dut_lane(o) !== exp_v[o]) begin
        errors++;
        $display("FAIL collision_old_weights lane%0d: got %0d, required %0d", o, dut_lane(o), exp_v[o]);
      end
    end
    iReady_BM_RcAccum = 1'b1;
    @(negedge iCLK);
    iReady_BM_RcAccum = 1'b0;
    checks++;
    if (oReady_AS_Weight !== 1'b1) begin
      errors++;
      $display("FAIL collision_weight_after: wready=%b, required 1", oReady_AS_Weight);
    end
    @(negedge iCLK);
    iValid_AS_Weight = 1'b0;
    wm[0][0] = 5;
    wm[0][1] = -3;
    run_vector(8'h01, 0, "new_weight");
  endtask

  task automatic test_reset_abort;
    for (int k = 0; k < 2; k++) begin
      int n;
      n = 0;
      iData_AS_Spike  = 8'hFF;
      iValid_AS_Spike = 1'b1;
      while (oReady_AS_Spike !== 1'b1 && n < 200) begin @(negedge iCLK); n++; end
      @(negedge iCLK);
      iValid_AS_Spike = 1'b0;
      if (k == 0) repeat (3) @(negedge iCLK);
      else begin
        n = 0;
        while (oValid_BM_RcAccum !== 1'b1 && n < 200) begin @(negedge iCLK); n++; end
        checks++;
        if (oValid_BM_RcAccum !== 1'b1) begin
          errors++;
          $display("FAIL abort_reach_out: valid=%b, required 1", oValid_BM_RcAccum);
        end
      end
      #2 iRST = 1'b0;
      #1;
      checks++;
      if (oValid_BM_RcAccum !== 1'b0 || oData_BM_RcAccum !== '0 ||
          oReady_AS_Spike !== 1'b0 || oReady_AS_Weight !== 1'b0) begin
        errors++;
        $display("FAIL abort_%0d async: valid=%b data=%h sr=%b wr=%b, required all 0",
                 k, oValid_BM_RcAccum, oData_BM_RcAccum, oReady_AS_Spike, oReady_AS_Weight);
      end
      @(negedge iCLK);
      iRST = 1'b1;
      @(negedge iCLK);
      run_vector(8'hFF, 0, "after_abort");
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 16; it++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++)
        write_weight($urandom_range(0, NH), int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      run_vector(NH'($urandom), $urandom_range(0, 3), "random");
    end
  endtask

`ifdef RC_ACCUM_BIAS_EN
  task automatic test_bias;
    for (int a = 0; a < NH; a++) write_weight(a, 7, -8);
    write_weight(NH, 7, -8);
    run_vector(8'hFF, 0, "bias_saturate");
    run_vector(8'h00, 0, "bias_only");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_collision();
    test_reset_abort();
    write_weight(NH, 3, 3);
    run_vector(8'h01, 0, "addr_nh_write");
    test_random();
`ifdef RC_ACCUM_BIAS_EN
    test_bias();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
